store_buffer: RTL

- Sits directly downstream of the store byte-mask stage.
- Accepts each masked store (word address, 4-bit byte write-enable, lane-aligned data) from the X/M boundary and holds it in a small in-order FIFO.
- Drains stores to the data-memory port over a valid/ready handshake, so a busy memory port does not stall the pipeline until the buffer fills.
- Combines a new store into the youngest non-issuing entry when the word addresses match, and flags loads that hit a pending store.

---
 rtl/store_buffer_pkg.sv | 29 ++
 rtl/store_buffer_match.sv | 23 ++
 rtl/store_buffer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store buffer.
// Entry layout and byte-lane merge used by the top and its matcher.
package store_buffer_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int SB_AWIDTH      = 30;
  localparam int SB_DWIDTH      = 32;

  typedef struct packed {
    logic                     valid;
    logic [SB_AWIDTH-1:0]     addr;
    logic [BYTES_PER_WORD-1:0] mask;
    logic [SB_DWIDTH-1:0]     data;
  } sb_entry_t;

  function automatic logic [SB_DWIDTH-1:0] byte_merge(
    input logic [SB_DWIDTH-1:0]      old_data,
    input logic [SB_DWIDTH-1:0]      new_data,
    input logic [BYTES_PER_WORD-1:0] mask
  );
    logic [SB_DWIDTH-1:0] r;
    r = old_data;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (mask[i]) r[i*8 +: 8] = new_data[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Per-entry word-address comparator against a probe address.
// Returns the hit vector and its OR reduction.
module store_buffer_match #(
  parameter int DEPTH  = 4,
  parameter int AWIDTH = 30
) (
  input  logic [DEPTH-1:0]             valid_vec,
  input  logic [DEPTH-1:0][AWIDTH-1:0] addr_vec,
  input  logic [AWIDTH-1:0]            probe_addr,
  output logic [DEPTH-1:0]             hit_vec,
  output logic                         hit_any
);

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec[i] = valid_vec[i] & (addr_vec[i] == probe_addr);
    end
  end

  assign hit_any = |hit_vec;

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between the store-mask stage and data memory.
// Combines into the youngest non-head entry and flags load hazards.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int AWIDTH = SB_AWIDTH,
  parameter int DWIDTH = SB_DWIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_valid_i,
  output logic                       enq_ready_o,
  input  logic [AWIDTH-1:0]          enq_addr_i,
  input  logic [3:0]                 enq_mask_i,
  input  logic [DWIDTH-1:0]          enq_data_i,
  output logic                       mem_req_valid_o,
  input  logic                       mem_req_ready_i,
  output logic [AWIDTH-1:0]          mem_req_addr_o,
  output logic [3:0]                 mem_req_mask_o,
  output logic [DWIDTH-1:0]          mem_req_data_o,
  input  logic                       ld_check_valid_i,
  input  logic [AWIDTH-1:0]          ld_check_addr_i,
  output logic                       ld_hazard_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  sb_entry_t       ent [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   yng;
  logic [CW-1:0]   count;

  logic enq_fire;
  logic mask_nz;
  logic combine;
  logic push;
  logic deq;

  assign yng         = tail - PW'(1);
  assign enq_ready_o = (count != CW'(DEPTH));
  assign enq_fire    = enq_valid_i & enq_ready_o;
  assign mask_nz     = |enq_mask_i;

  // count >= 2 guarantees the youngest entry is never the head
  assign combine = enq_fire & mask_nz
                 & (count >= CW'(2))
                 & (ent[yng].addr == enq_addr_i);
  assign push    = enq_fire & mask_nz & ~combine;

  assign mem_req_valid_o = (count != '0);
  assign deq             = mem_req_valid_o & mem_req_ready_i;
  assign mem_req_addr_o  = ent[head].addr;
  assign mem_req_mask_o  = ent[head].mask;
  assign mem_req_data_o  = ent[head].data;

  assign empty_o = (count == '0);
  assign count_o = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i].valid <= 1'b0;
      end
    end else begin
      if (deq) begin
        ent[head].valid <= 1'b0;
        head            <= head + PW'(1);
      end
      if (push) begin
        ent[tail].valid <= 1'b1;
        ent[tail].addr  <= enq_addr_i;
        ent[tail].mask  <= enq_mask_i;
        ent[tail].data  <= enq_data_i;
        tail            <= tail + PW'(1);
      end
      if (combine) begin
        ent[yng].mask <= ent[yng].mask | enq_mask_i;
        ent[yng].data <= byte_merge(ent[yng].data,
                                    enq_data_i,
                                    enq_mask_i);
      end
      count <= count + CW'(push) - CW'(deq);
    end
  end

  logic [DEPTH-1:0]             valid_vec;
  logic [DEPTH-1:0][AWIDTH-1:0] addr_vec;
  logic [DEPTH-1:0]             ld_hit_vec;
  logic                         ld_hit_any;

  always_comb begin
    valid_vec = '0;
    addr_vec  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = ent[i].valid;
      addr_vec[i]  = ent[i].addr;
    end
  end

  store_buffer_match #(
    .DEPTH  (DEPTH),
    .AWIDTH (AWIDTH)
  ) u_match (
    .valid_vec  (valid_vec),
    .addr_vec   (addr_vec),
    .probe_addr (ld_check_addr_i),
    .hit_vec    (ld_hit_vec),
    .hit_any    (ld_hit_any)
  );

  assign ld_hazard_o = ld_check_valid_i & ld_hit_any
                     & (ld_hit_vec != '0);

endmodule
